// File: rtl/udp_multi_fifo_packer.sv
// Packs samples from several show-ahead source FIFOs into one UDP payload stream
// (4-byte header + sample-major data) and posts a {byte_count, ip, mac} status word.
module udp_multi_fifo_packer #(
    parameter int AVL_SIZE    = 8,
    parameter int BYTE_SIZE   = 8,
    parameter int IP_SIZE     = 32,
    parameter int MAC_SIZE    = 48,
    parameter int FIFO_LENGTH = 16,
    parameter int nOfFifos    = 4,
    parameter int MAX_SAMPLES = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [nOfFifos-1:0]                   channel_mask,
    input  logic [$clog2(MAX_SAMPLES+1)-1:0]      samples_per_packet,
    input  logic [MAC_SIZE-1:0]                   destination_mac,
    input  logic [IP_SIZE-1:0]                    destination_ip,
    output logic [AVL_SIZE-1:0]                   tx_fifo_data,
    output logic                                  tx_fifo_data_write,
    input  logic                                  tx_fifo_data_full,
    output logic [16+IP_SIZE+MAC_SIZE-1:0]        tx_fifo_status,
    output logic                                  tx_fifo_status_write,
    input  logic                                  tx_fifo_status_full,
    output logic [nOfFifos-1:0]                   rdreq_fifo,
    input  logic [nOfFifos*FIFO_LENGTH-1:0]       rddata_fifo,
    input  logic [nOfFifos-1:0]                   rdempty_fifo,
    output logic [15:0]                           seq_number,
    output logic                                  busy
);
    localparam int BYTE_IN_FIFO = FIFO_LENGTH / 8;
    localparam int SPP_W = $clog2(MAX_SAMPLES + 1);
    localparam int CH_W  = (nOfFifos > 1) ? $clog2(nOfFifos) : 1;
    localparam int BW    = (BYTE_IN_FIFO > 1) ? $clog2(BYTE_IN_FIFO) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HEADER    = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_POP       = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_WAIT_DATA = 3'd5;
    localparam logic [2:0] S_TRANSMIT  = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [1:0]          hdr_q, hdr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BW-1:0]       b_q, b_d;
    logic [SPP_W-1:0]    smp_q, smp_d, spp_q, spp_d;
    logic [nOfFifos-1:0] mask_q, mask_d;
    logic [15:0]         cnt_q, cnt_d, seq_q, seq_d;

    // Lowest enabled channel with index >= from; nOfFifos when none is left.
    function automatic int next_ch(input logic [nOfFifos-1:0] m, input int from);
        int r;
        r = nOfFifos;
        for (int i = nOfFifos - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [15:0] popcnt(input logic [nOfFifos-1:0] m);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < nOfFifos; i++) c = c + 16'(m[i]);
        return c;
    endfunction

    logic                   spp_ok, start_ok, data_ok;
    logic [FIFO_LENGTH-1:0] word;
    logic [AVL_SIZE-1:0]    cur_byte;
    int                     nxt;

    assign spp_ok   = (samples_per_packet != '0) && (samples_per_packet <= SPP_W'(MAX_SAMPLES));
    assign start_ok = enable && (channel_mask != '0) && spp_ok && ((rdempty_fifo & channel_mask) == '0);
    assign data_ok  = (rdempty_fifo & mask_q) == '0;
    assign nxt      = next_ch(mask_q, int'(ch_q) + 1);
    assign word     = rddata_fifo[int'(ch_q)*FIFO_LENGTH +: FIFO_LENGTH];

    always_comb begin
        cur_byte = '0;
        if (state_q == S_HEADER) begin
            case (hdr_q)
                2'd0:    cur_byte = AVL_SIZE'(8'hA5);
                2'd1:    cur_byte = AVL_SIZE'(seq_q[15:8]);
                2'd2:    cur_byte = AVL_SIZE'(seq_q[7:0]);
                default: cur_byte = AVL_SIZE'(8'(mask_q));
            endcase
        end else begin
            // MSB byte of the word goes out first.
            cur_byte = AVL_SIZE'(word >> ((BYTE_IN_FIFO - 1 - int'(b_q)) * BYTE_SIZE));
        end
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        ch_d    = ch_q;
        b_d     = b_q;
        smp_d   = smp_q;
        spp_d   = spp_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        case (state_q)
            S_IDLE: if (start_ok) begin
                mask_d  = channel_mask;
                spp_d   = samples_per_packet;
                cnt_d   = 16'd4 + popcnt(channel_mask) * 16'(BYTE_IN_FIFO) * 16'(samples_per_packet);
                hdr_d   = '0;
                b_d     = '0;
                smp_d   = '0;
                state_d = S_HEADER;
            end
            S_HEADER: if (!tx_fifo_data_full) begin
                if (hdr_q == 2'd3) begin
                    ch_d    = CH_W'(next_ch(mask_q, 0));
                    state_d = S_DATA;
                end else begin
                    hdr_d = hdr_q + 2'd1;
                end
            end
            S_DATA: if (!tx_fifo_data_full) begin
                if (b_q == BW'(BYTE_IN_FIFO - 1)) begin
                    b_d = '0;
                    if (nxt >= nOfFifos) state_d = S_POP;
                    else                 ch_d    = CH_W'(nxt);
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            S_POP: begin
                smp_d   = smp_q + 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (smp_q < spp_q) begin
                    ch_d    = CH_W'(next_ch(mask_q, 0));
                    state_d = data_ok ? S_DATA : S_WAIT_DATA;
                end else begin
                    state_d = S_TRANSMIT;
                end
            end
            S_WAIT_DATA: if (data_ok) state_d = S_DATA;
            S_TRANSMIT: if (!tx_fifo_status_full) begin
                seq_d   = seq_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            ch_q    <= '0;
            b_q     <= '0;
            smp_q   <= '0;
            spp_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            ch_q    <= ch_d;
            b_q     <= b_d;
            smp_q   <= smp_d;
            spp_q   <= spp_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
        end
    end

    // Outputs are gated by reset so they read zero even on the cycle reset arrives.
    assign tx_fifo_data_write   = !reset && (state_q == S_HEADER || state_q == S_DATA) && !tx_fifo_data_full;
    assign tx_fifo_data         = tx_fifo_data_write ? cur_byte : '0;
    assign tx_fifo_status_write = !reset && (state_q == S_TRANSMIT) && !tx_fifo_status_full;
    assign tx_fifo_status       = tx_fifo_status_write ? {cnt_q, destination_ip, destination_mac} : '0;
    assign rdreq_fifo           = (!reset && state_q == S_POP) ? mask_q : '0;
    assign busy                 = !reset && (state_q != S_IDLE);
    assign seq_number           = reset ? 16'd0 : seq_q;
endmodule

// File: doc/udp_multi_fifo_packer.md
UDP_MULTI_FIFO_PACKER -- requirements
Module: udp_multi_fifo_packer

Parameters
REQ-001 AVL_SIZE, 8, width of the TX data FIFO byte lane.
REQ-002 BYTE_SIZE, 8, bits per byte.
REQ-003 IP_SIZE, 32, IP address width.
REQ-004 MAC_SIZE, 48, MAC address width.
REQ-005 FIFO_LENGTH, 16, source FIFO word width; SHALL be a multiple of 8; BYTE_IN_FIFO = FIFO_LENGTH/8.
REQ-006 nOfFifos, 4, number of source channels, 1..8.
REQ-007 MAX_SAMPLES, 64, upper bound on samples per channel per packet.

Interface
REQ-008 clk  in  1  125 MHz clock; one clock, synchronous and active-high reset.
REQ-009 reset  in  1  synchronous, active-high.
REQ-010 enable  in  1  permits new packets; sampled only in IDLE.
REQ-011 channel_mask  in  nOfFifos  bit i=1 includes channel i.
REQ-012 samples_per_packet  in  $clog2(MAX_SAMPLES+1)  words per enabled channel per packet.
REQ-013 destination_mac / destination_ip  in  MAC_SIZE / IP_SIZE  packet destination.
REQ-014 tx_fifo_data  out  AVL_SIZE  payload byte.
REQ-015 tx_fifo_data_write  out  1  byte write strobe.
REQ-016 tx_fifo_data_full  in  1  data FIFO full.
REQ-017 tx_fifo_status  out  16+IP_SIZE+MAC_SIZE  {byte_count[15:0], ip, mac}.
REQ-018 tx_fifo_status_write  out  1  status write strobe; triggers transmission.
REQ-019 tx_fifo_status_full  in  1  status FIFO full.
REQ-020 rdreq_fifo  out  nOfFifos  per-channel read request (show-ahead FIFOs).
REQ-021 rddata_fifo  in  nOfFifos*FIFO_LENGTH  channel i at bits [FIFO_LENGTH*(i+1)-1 : FIFO_LENGTH*i].
REQ-022 rdempty_fifo  in  nOfFifos  per-channel empty.
REQ-023 seq_number  out  16  sequence number of the next packet.
REQ-024 busy  out  1  high in every state except IDLE.

Function
REQ-025 States: IDLE, HEADER, DATA, POP, SETTLE, WAIT_DATA, TRANSMIT.
REQ-026 In IDLE, mask, spp and byte_count SHALL be latched when enable=1, mask!=0, spp in 1..MAX_SAMPLES and all enabled channels are non-empty; the block then goes to HEADER. Otherwise it stays in IDLE.
REQ-027 Header = 4 bytes, in order: 8'hA5, seq[15:8], seq[7:0], mask zero-extended to 8 bits.
REQ-028 Payload SHALL be ordered sample-major: for each sample, enabled channels in ascending index; for each word, MSB byte first.
REQ-029 byte_count = 4 + popcount(mask)*BYTE_IN_FIFO*spp, truncated to 16 bits.
REQ-030 Byte handshake: on a cycle with tx_fifo_data_full=1, write=0 and there is no progress. Otherwise write=1 with the current byte and the block advances by one byte. No byte SHALL be dropped or duplicated.
REQ-031 Disabled channels SHALL be skipped with no idle cycle and SHALL never see rdreq.
REQ-032 After the last byte of a sample, POP SHALL assert rdreq for exactly one cycle on the latched-enabled channels only.
REQ-033 SETTLE SHALL last one cycle with rdreq=0, so the empty flags can update.
REQ-034 After SETTLE, if samples remain: go to DATA if all enabled channels are non-empty, else go to WAIT_DATA and hold until they are. Otherwise go to TRANSMIT.
REQ-035 TRANSMIT: hold while tx_fifo_status_full=1. Otherwise pulse status_write for one cycle with {byte_count, ip, mac}, increment seq (wrapping FFFF->0000), and return to IDLE.
REQ-036 ip and mac SHALL be sampled in the TRANSMIT cycle that writes the status.
REQ-037 Changes to mask, spp or enable during a packet SHALL have no effect until the next IDLE.
REQ-038 Minimum spacing between packets SHALL be one IDLE cycle.

Reset
REQ-039 While reset=1: all write strobes and rdreq=0, seq=0, state=IDLE, counters=0, busy=0, tx_fifo_data=0, tx_fifo_status=0.
REQ-040 Reset mid-packet SHALL abort the packet with no status write; partial data already written is the downstream's concern.

Verification
REQ-041 nOfFifos=4, mask=4'hF, spp=1, ch0..3 = 1111,2222,3333,4444 -> bytes A5 00 00 0F 11 11 22 22 33 33 44 44; status count=12; one rdreq per channel; seq becomes 1.
REQ-042 mask=4'b0101, spp=2 -> only ch0/ch2 bytes, interleaved per sample; count=12; rdreq[1] and rdreq[3] never asserted.
REQ-043 tx_fifo_data_full asserted for 3 cycles mid-payload -> byte stream identical to the unstalled case; write=0 during the stall.
REQ-044 ch2 empties after sample 1 with spp=3 -> WAIT_DATA until refilled; output is still correct; busy held high.
REQ-045 seq preset to FFFF via 65535 packets (or forced) -> header FF FF, next header 00 00; tx_fifo_status_full held 5 cycles -> a single status_write after release.
REQ-046 Reset asserted in DATA -> next cycle IDLE, no status_write, seq=0; mask=0 or spp=0 -> no activity.
